mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
Parameters (all macros from core/constants.v; no module parameters):
REQ-001 CONTROL_SIGNALS_WIDTH, codebase value, width of the control bundle.
REQ-002 CTRL_MEM_READ / CTRL_MEM_WRITE, codebase bit indices, load / store request bits.
REQ-003 CTRL_MEM_WIDTH, codebase 2-bit field, access size: MEM_BYTE, MEM_HALF, MEM_WORD.
REQ-004 CTRL_MEM_UNSIGNED, codebase bit index, 1 = zero-extend loads, 0 = sign-extend.
Ports:
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 ex_mem_pc / ex_mem_alu_result / ex_mem_rs2_data  in  32 each  PC, effective address or ALU value, store data.
REQ-008 ex_mem_rd_addr  in  5  destination register.
REQ-009 ex_mem_control_signals  in  CONTROL_SIGNALS_WIDTH  control bundle.
REQ-010 ex_mem_valid  in  1  instruction in EX/MEM is valid.
REQ-011 dmem_addr  out  32  memory address; dmem_data_in  in  32  read word, combinational (same-cycle) from memory.
REQ-012 dmem_data_out  out  32  store data, lane-aligned; dmem_read / dmem_write  out  1; dmem_byte_enable  out  4  per-byte lane enables.
REQ-013 mem_wb_pc, mem_wb_alu_result, mem_wb_mem_data  out  32; mem_wb_rd_addr  out  5; mem_wb_control_signals  out  CONTROL_SIGNALS_WIDTH; mem_wb_valid  out  1.

Function
REQ-014 All dmem_* outputs SHALL be purely combinational from ex_mem_* inputs.
REQ-015 dmem_addr = ex_mem_alu_result, unmodified (no alignment masking).
REQ-016 dmem_read = ex_mem_valid & CTRL_MEM_READ; dmem_write = ex_mem_valid & CTRL_MEM_WRITE.
REQ-017 Lane offset off = ex_mem_alu_result[1:0]; byte: enable 1<<off; half: 4'b0011 if off[1]=0 else 4'b1100 (off[0] ignored); word: 4'b1111 (off ignored).
REQ-018 dmem_byte_enable = 4'b0000 when neither dmem_read nor dmem_write is asserted.
REQ-019 dmem_data_out: byte = rs2[7:0] replicated in all 4 lanes; half = rs2[15:0] replicated in both halves; word = rs2.
REQ-020 Load extraction: byte = dmem_data_in[8*off+7:8*off]; half = dmem_data_in[31:16] if off[1] else [15:0]; word = dmem_data_in.
REQ-021 Byte/half results zero-extended when CTRL_MEM_UNSIGNED=1, sign-extended from bit 7/15 otherwise; word unaffected.
REQ-022 Extracted load data = 0 when dmem_read is 0.
REQ-023 CTRL_MEM_WIDTH encoding not byte/half/word SHALL be treated as word.
REQ-024 On each rising edge (reset low), the MEM/WB register SHALL capture: pc, alu_result, extracted load data, rd_addr, control_signals, valid = ex_mem_valid; latency exactly 1 cycle.
REQ-025 Invalid instructions still propagate pc/alu_result/rd/control, with mem_wb_valid=0.
REQ-026 No stall or flush inputs; the register updates every cycle.
REQ-027 Misaligned accesses raise no exception; behaviour follows REQ-017/REQ-020.

Reset
REQ-028 reset=1 SHALL immediately (asynchronously) clear every mem_wb_* output to 0, including mem_wb_valid.
REQ-029 Reset asserted mid-operation discards the in-flight capture; dmem_* outputs remain combinational during reset.

Verification
REQ-030 LBU: addr 0x0, dmem_data_in 0x123456FF, read, byte, unsigned -> after one edge mem_wb_mem_data = 0x000000FF.
REQ-031 LB: addr 0x0, data 0x12345680, signed -> 0xFFFFFF80; LHU: addr 0x2, data 0xFFFF1234 -> 0x0000FFFF.
REQ-032 LH: addr 0x2, data 0x80001234, signed -> 0xFFFF8000; LW: addr 0x0, data 0xCAFEBABE -> 0xCAFEBABE.
REQ-033 SW: addr 0x10000000, rs2 0x12345678, write, word, valid -> within 1 ns dmem_addr 0x10000000, dmem_data_out 0x12345678, dmem_write 1, dmem_byte_enable 4'b1111.
REQ-034 SB addr 0x3, rs2 0x000000AB -> data_out 0xABABABAB, byte_enable 4'b1000; SH addr 0x2 -> byte_enable 4'b1100.
REQ-035 Assert reset while valid load in flight -> all mem_wb_* = 0 without waiting for a clock edge; ex_mem_valid=0 store -> dmem_write 0, byte_enable 0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory access stage: drives the data-memory port combinationally from the
// EX/MEM inputs, extracts and extends load data, and registers the MEM/WB bundle.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ex_mem_pc,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_rs2_data,
    input  logic [4:0]  ex_mem_rd_addr,
    input  logic [15:0] ex_mem_control_signals,
    input  logic        ex_mem_valid,
    output logic [31:0] dmem_addr,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_byte_enable,
    output logic [31:0] mem_wb_pc,
    output logic [31:0] mem_wb_alu_result,
    output logic [31:0] mem_wb_mem_data,
    output logic [4:0]  mem_wb_rd_addr,
    output logic [15:0] mem_wb_control_signals,
    output logic        mem_wb_valid
);

    // Control bundle layout shared with the rest of the core.
    localparam int unsigned CONTROL_SIGNALS_WIDTH = 16;
    localparam int unsigned CTRL_MEM_READ         = 0;
    localparam int unsigned CTRL_MEM_WRITE        = 1;
    localparam int unsigned CTRL_MEM_WIDTH_LO     = 2;
    localparam int unsigned CTRL_MEM_WIDTH_HI     = 3;
    localparam int unsigned CTRL_MEM_UNSIGNED     = 4;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    logic [1:0]  mem_width;
    logic [1:0]  lane_off;
    logic        mem_unsigned;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign mem_width    = ex_mem_control_signals[CTRL_MEM_WIDTH_HI:CTRL_MEM_WIDTH_LO];
    assign lane_off     = ex_mem_alu_result[1:0];
    assign mem_unsigned = ex_mem_control_signals[CTRL_MEM_UNSIGNED];

    // Memory request: address, strobes, lane enables and replicated store data.
    always_comb begin
        dmem_addr        = ex_mem_alu_result;
        dmem_read        = ex_mem_valid & ex_mem_control_signals[CTRL_MEM_READ];
        dmem_write       = ex_mem_valid & ex_mem_control_signals[CTRL_MEM_WRITE];
        dmem_byte_enable = 4'b1111;
        dmem_data_out    = ex_mem_rs2_data;
        case (mem_width)
            MEM_BYTE: begin
                dmem_byte_enable = 4'b0001 << lane_off;
                dmem_data_out    = {4{ex_mem_rs2_data[7:0]}};
            end
            MEM_HALF: begin
                dmem_byte_enable = lane_off[1] ? 4'b1100 : 4'b0011;
                dmem_data_out    = {2{ex_mem_rs2_data[15:0]}};
            end
            default: begin
                dmem_byte_enable = 4'b1111;
                dmem_data_out    = ex_mem_rs2_data;
            end
        endcase
        if (!(dmem_read || dmem_write)) begin
            dmem_byte_enable = 4'b0000;
        end
    end

    // Load lane select and sign/zero extension; zero when no read is issued.
    always_comb begin
        case (lane_off)
            2'd0:    load_byte = dmem_data_in[7:0];
            2'd1:    load_byte = dmem_data_in[15:8];
            2'd2:    load_byte = dmem_data_in[23:16];
            default: load_byte = dmem_data_in[31:24];
        endcase
        load_half = lane_off[1] ? dmem_data_in[31:16] : dmem_data_in[15:0];
        load_data = dmem_data_in;
        case (mem_width)
            MEM_BYTE: load_data = mem_unsigned ? {24'h0, load_byte}
                                               : {{24{load_byte[7]}}, load_byte};
            MEM_HALF: load_data = mem_unsigned ? {16'h0, load_half}
                                               : {{16{load_half[15]}}, load_half};
            default:  load_data = dmem_data_in;
        endcase
        if (!dmem_read) begin
            load_data = 32'h0;
        end
    end

    // MEM/WB pipeline register, updated every cycle, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wb_pc              <= 32'h0;
            mem_wb_alu_result      <= 32'h0;
            mem_wb_mem_data        <= 32'h0;
            mem_wb_rd_addr         <= 5'h0;
            mem_wb_control_signals <= CONTROL_SIGNALS_WIDTH'(0);
            mem_wb_valid           <= 1'b0;
        end else begin
            mem_wb_pc              <= ex_mem_pc;
            mem_wb_alu_result      <= ex_mem_alu_result;
            mem_wb_mem_data        <= load_data;
            mem_wb_rd_addr         <= ex_mem_rd_addr;
            mem_wb_control_signals <= ex_mem_control_signals;
            mem_wb_valid           <= ex_mem_valid;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed load/store vectors, immediate checks on the
// combinational memory port, and a queue-based monitor on the MEM/WB register.
module tb_mem_stage;

    localparam logic [1:0] W_B = 2'b00;
    localparam logic [1:0] W_H = 2'b01;
    localparam logic [1:0] W_W = 2'b10;
    localparam logic [1:0] W_X = 2'b11;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] mem_data;
        logic [4:0]  rd;
        logic [15:0] ctrl;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ex_mem_pc = '0;
    logic [31:0] ex_mem_alu_result = '0;
    logic [31:0] ex_mem_rs2_data = '0;
    logic [4:0]  ex_mem_rd_addr = '0;
    logic [15:0] ex_mem_control_signals = '0;
    logic        ex_mem_valid = 1'b0;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_data_in = '0;
    logic [31:0] dmem_data_out;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] mem_wb_pc;
    logic [31:0] mem_wb_alu_result;
    logic [31:0] mem_wb_mem_data;
    logic [4:0]  mem_wb_rd_addr;
    logic [15:0] mem_wb_control_signals;
    logic        mem_wb_valid;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    mem_stage dut (
        .clk(clk), .reset(reset),
        .ex_mem_pc(ex_mem_pc), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_rs2_data(ex_mem_rs2_data), .ex_mem_rd_addr(ex_mem_rd_addr),
        .ex_mem_control_signals(ex_mem_control_signals), .ex_mem_valid(ex_mem_valid),
        .dmem_addr(dmem_addr), .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
        .mem_wb_pc(mem_wb_pc), .mem_wb_alu_result(mem_wb_alu_result),
        .mem_wb_mem_data(mem_wb_mem_data), .mem_wb_rd_addr(mem_wb_rd_addr),
        .mem_wb_control_signals(mem_wb_control_signals), .mem_wb_valid(mem_wb_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Control word: upper bits carry unrelated pipeline controls to prove passthrough.
    function automatic logic [15:0] mk_ctrl(input logic rd, input logic wr,
                                            input logic [1:0] w, input logic uns);
        return {11'b101_0000_0110, uns, w, wr, rd};
    endfunction

    // Drive one EX/MEM vector, check the memory port, queue the MEM/WB expectation.
    task automatic issue(input string name, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic [15:0] ctrl,
                         input logic valid, input logic [31:0] din,
                         input logic exp_rd, input logic exp_wr, input logic [3:0] exp_be,
                         input logic [31:0] exp_dout, input logic [31:0] exp_mem);
        exp_t e;
        @(negedge clk);
        ex_mem_pc = pc; ex_mem_alu_result = alu; ex_mem_rs2_data = rs2;
        ex_mem_rd_addr = rd; ex_mem_control_signals = ctrl; ex_mem_valid = valid;
        dmem_data_in = din;
        #1;
        chk({name, ".addr"}, dmem_addr, alu);
        chk({name, ".read"}, 32'(dmem_read), 32'(exp_rd));
        chk({name, ".write"}, 32'(dmem_write), 32'(exp_wr));
        chk({name, ".be"}, 32'(dmem_byte_enable), 32'(exp_be));
        chk({name, ".dout"}, dmem_data_out, exp_dout);
        e = '{pc: pc, alu: alu, mem_data: exp_mem, rd: rd, ctrl: ctrl, valid: valid};
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: one captured MEM/WB bundle per issued vector, one edge later.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wb.pc", mem_wb_pc, e.pc);
            chk("wb.alu", mem_wb_alu_result, e.alu);
            chk("wb.mem_data", mem_wb_mem_data, e.mem_data);
            chk("wb.rd", 32'(mem_wb_rd_addr), 32'(e.rd));
            chk("wb.ctrl", 32'(mem_wb_control_signals), 32'(e.ctrl));
            chk("wb.valid", 32'(mem_wb_valid), 32'(e.valid));
        end
    end

    task automatic chk_wb_zero(input string name);
        chk({name, ".pc"}, mem_wb_pc, 32'h0);
        chk({name, ".alu"}, mem_wb_alu_result, 32'h0);
        chk({name, ".mem_data"}, mem_wb_mem_data, 32'h0);
        chk({name, ".rd"}, 32'(mem_wb_rd_addr), 32'h0);
        chk({name, ".ctrl"}, 32'(mem_wb_control_signals), 32'h0);
        chk({name, ".valid"}, 32'(mem_wb_valid), 32'h0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #2 chk_wb_zero("rst_init");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Loads: name pc alu rs2 rd ctrl valid din | rd wr be dout mem
        issue("lbu", 32'h100, 32'h0, 32'h0, 5'd1, mk_ctrl(1,0,W_B,1), 1, 32'h123456FF,
              1, 0, 4'b0001, 32'h0, 32'h000000FF);
        issue("lb", 32'h104, 32'h0, 32'h0, 5'd2, mk_ctrl(1,0,W_B,0), 1, 32'h12345680,
              1, 0, 4'b0001, 32'h0, 32'hFFFFFF80);
        issue("lhu", 32'h108, 32'h2, 32'h0, 5'd3, mk_ctrl(1,0,W_H,1), 1, 32'hFFFF1234,
              1, 0, 4'b1100, 32'h0, 32'h0000FFFF);
        issue("lh", 32'h10C, 32'h2, 32'h0, 5'd4, mk_ctrl(1,0,W_H,0), 1, 32'h80001234,
              1, 0, 4'b1100, 32'h0, 32'hFFFF8000);
        issue("lw", 32'h110, 32'h0, 32'h0, 5'd5, mk_ctrl(1,0,W_W,0), 1, 32'hCAFEBABE,
              1, 0, 4'b1111, 32'h0, 32'hCAFEBABE);
        issue("lb_off1", 32'h114, 32'h5, 32'h0, 5'd6, mk_ctrl(1,0,W_B,0), 1, 32'h00009A00,
              1, 0, 4'b0010, 32'h0, 32'hFFFFFF9A);
        issue("lbu_off3", 32'h118, 32'h3, 32'h0, 5'd7, mk_ctrl(1,0,W_B,1), 1, 32'hAB000000,
              1, 0, 4'b1000, 32'h0, 32'h000000AB);
        issue("lh_off3", 32'h11C, 32'h3, 32'h0, 5'd8, mk_ctrl(1,0,W_H,0), 1, 32'h7FFF0000,
              1, 0, 4'b1100, 32'h0, 32'h00007FFF);
        issue("lw_wx_unal", 32'h120, 32'h7, 32'h0, 5'd9, mk_ctrl(1,0,W_X,1), 1, 32'h11223344,
              1, 0, 4'b1111, 32'h0, 32'h11223344);
        // Stores: load data must stay zero even with data on the bus.
        issue("sw", 32'h124, 32'h10000000, 32'h12345678, 5'd0, mk_ctrl(0,1,W_W,0), 1, 32'hDEADBEEF,
              0, 1, 4'b1111, 32'h12345678, 32'h0);
        issue("sb_off3", 32'h128, 32'h3, 32'h000000AB, 5'd0, mk_ctrl(0,1,W_B,0), 1, 32'h0,
              0, 1, 4'b1000, 32'hABABABAB, 32'h0);
        issue("sh_off2", 32'h12C, 32'h2, 32'h0000BEEF, 5'd0, mk_ctrl(0,1,W_H,0), 1, 32'h0,
              0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0);
        issue("sb_off1", 32'h130, 32'h1, 32'h12345677, 5'd0, mk_ctrl(0,1,W_B,0), 1, 32'h0,
              0, 1, 4'b0010, 32'h77777777, 32'h0);
        // Invalid and non-memory instructions.
        issue("sw_invalid", 32'h134, 32'h40, 32'h55AA55AA, 5'd10, mk_ctrl(0,1,W_W,0), 0, 32'h0,
              0, 0, 4'b0000, 32'h55AA55AA, 32'h0);
        issue("lw_invalid", 32'h138, 32'h44, 32'h0, 5'd11, mk_ctrl(1,0,W_W,0), 0, 32'h55555555,
              0, 0, 4'b0000, 32'h0, 32'h0);
        issue("alu_op", 32'h13C, 32'hA5A5A5A5, 32'h0, 5'd12, mk_ctrl(0,0,W_W,0), 1, 32'h77777777,
              0, 0, 4'b0000, 32'h0, 32'h0);
        drain();

        // Asynchronous reset while a valid load sits at the stage input.
        issue("lw_pre_rst", 32'h200, 32'h8, 32'h0, 5'd13, mk_ctrl(1,0,W_W,0), 1, 32'h0BADF00D,
              1, 0, 4'b1111, 32'h0, 32'h0BADF00D);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_wb_zero("rst_async");
        chk("rst.dmem_read_comb", 32'(dmem_read), 32'd1);
        chk("rst.dmem_be_comb", 32'(dmem_byte_enable), 32'hF);
        @(posedge clk);
        #1;
        chk_wb_zero("rst_hold");
        @(negedge clk);
        ex_mem_valid = 1'b0;
        reset = 1'b0;

        issue("lbu_post_rst", 32'h300, 32'h1, 32'h0, 5'd14, mk_ctrl(1,0,W_B,1), 1, 32'h0000C300,
              1, 0, 4'b0010, 32'h0, 32'h000000C3);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
